// File: rtl/cdu_pkg.sv
// Shared definitions for the cdu48 counter family.
//   CDU_DEF_WIDTH / CDU_DEF_MODULUS : default register width and count modulus
//   CDU_DIGIT_LIMIT                 : values at or above this have no two-digit decimal form
//   cdu_is_legal()                  : 1 when a counter value lies inside 0..modulus-1
package cdu_pkg;

  localparam int unsigned CDU_DEF_WIDTH   = 8;
  localparam int unsigned CDU_DEF_MODULUS = 100;
  localparam int unsigned CDU_DIGIT_LIMIT = 100;

  function automatic logic cdu_is_legal(input logic [31:0] value, input logic [31:0] modulus);
    return value < modulus;
  endfunction

endpackage

// File: rtl/cdu48_up_counter_if.sv
// Counter control/status bundle.
//   ld, en, cai, d         : load strobe, count enable, carry-in, load data (master -> counter)
//   q, cao, ill, tens, ones : count value, carry-out, illegal flag, decimal digits (counter -> master)
interface cdu48_up_counter_if
  import cdu_pkg::*;
#(
  parameter int unsigned WIDTH = CDU_DEF_WIDTH
);
  logic             ld;
  logic             en;
  logic             cai;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             cao;
  logic             ill;
  logic [3:0]       tens;
  logic [3:0]       ones;

  modport master (
    output ld, en, cai, d,
    input  q, cao, ill, tens, ones
  );

  modport slave (
    input  ld, en, cai, d,
    output q, cao, ill, tens, ones
  );
endinterface

// File: rtl/cdu_digit_split.sv
// Combinational split of a 0..99 value into decimal tens/ones using compares and a
// subtract (no divider).
//   value      : binary input, 7 bits
//   force_zero : forces both digits to 0 (driven by the counter's illegal flag)
//   tens, ones : decimal digits; both 0 for values outside the two-digit range
module cdu_digit_split
  import cdu_pkg::*;
(
  input  logic [6:0] value,
  input  logic       force_zero,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  localparam logic [6:0] Limit = 7'(CDU_DIGIT_LIMIT);

  logic found;

  always_comb begin
    tens  = 4'd0;
    ones  = 4'(value);
    found = 1'b0;
    // Largest multiple of ten not exceeding value picks the tens digit.
    for (int k = 9; k >= 1; k--) begin
      if (!found && value >= 7'(k * 10)) begin
        found = 1'b1;
        tens  = 4'(k);
        ones  = 4'(value - 7'(k * 10));
      end
    end
    if (force_zero || value >= Limit) begin
      tens = 4'd0;
      ones = 4'd0;
    end
  end
endmodule

// File: rtl/cdu48_up_counter.sv
// Modulo-MODULUS up counter with clear, load, enable, cascade carry-in/out and decimal digits.
//   clk : rising-edge clock
//   cs  : synchronous active-high clear, highest priority
//   bus : slave side of cdu48_up_counter_if (ld/en/cai/d in; q/cao/ill/tens/ones out)
// Priority per edge: cs, ld, count, hold. Loaded values >= MODULUS freeze counting until
// cleared or reloaded.
module cdu48_up_counter
  import cdu_pkg::*;
#(
  parameter int unsigned WIDTH     = CDU_DEF_WIDTH,
  parameter int unsigned MODULUS   = CDU_DEF_MODULUS,
  parameter bit          DIGITS_EN = 1'b1
) (
  input logic                    clk,
  input logic                    cs,
  cdu48_up_counter_if.slave      bus
);
  // Terminal count held one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] TopVal = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             ill;
  logic             at_top;
  logic             count;

  always_comb begin
    ill    = !cdu_is_legal(32'(q_q), 32'(MODULUS));
    at_top = ({1'b0, q_q} == TopVal);
    count  = bus.en & bus.cai & ~ill;
    q_d    = q_q;
    if (bus.ld) begin
      q_d = bus.d;
    end else if (count) begin
      // Wrap at terminal count means q_q + 1 never exceeds MODULUS-1, so no overflow.
      q_d = at_top ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cs) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.ill = ill;
  // Not gated by ld/cs: the next stage resolves its own priority.
  assign bus.cao = bus.cai & bus.en & at_top;

  if (DIGITS_EN) begin : g_digits
    logic [6:0] val7;
    assign val7 = 7'(q_q);
    cdu_digit_split u_split (
      .value      (val7),
      .force_zero (ill),
      .tens       (bus.tens),
      .ones       (bus.ones)
    );
  end else begin : g_no_digits
    assign bus.tens = 4'd0;
    assign bus.ones = 4'd0;
  end
endmodule

// File: tb/tb_cdu48_up_counter.sv
module tb_cdu48_up_counter;
  logic clk;
  logic cs;
  int   checks;
  int   errors;

  cdu48_up_counter_if #(.WIDTH(8)) a_if ();
  cdu48_up_counter_if #(.WIDTH(8)) lo_if ();
  cdu48_up_counter_if #(.WIDTH(8)) hi_if ();
  cdu48_up_counter_if #(.WIDTH(8)) m_if ();

  cdu48_up_counter #(.WIDTH(8), .MODULUS(100), .DIGITS_EN(1'b1)) dut_a (
    .clk (clk), .cs (cs), .bus (a_if.slave)
  );
  cdu48_up_counter #(.WIDTH(8), .MODULUS(100), .DIGITS_EN(1'b1)) dut_lo (
    .clk (clk), .cs (cs), .bus (lo_if.slave)
  );
  cdu48_up_counter #(.WIDTH(8), .MODULUS(100), .DIGITS_EN(1'b1)) dut_hi (
    .clk (clk), .cs (cs), .bus (hi_if.slave)
  );
  cdu48_up_counter #(.WIDTH(8), .MODULUS(256), .DIGITS_EN(1'b0)) dut_m (
    .clk (clk), .cs (cs), .bus (m_if.slave)
  );

  // Cascade: low stage carry-out feeds high stage carry-in.
  assign hi_if.cai = lo_if.cao;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int q, input bit cao, input bit ill,
                         input int tens, input int ones);
    check({tag, ".q"}, 32'(a_if.q), 32'(q));
    check({tag, ".cao"}, 32'(a_if.cao), 32'(cao));
    check({tag, ".ill"}, 32'(a_if.ill), 32'(ill));
    check({tag, ".tens"}, 32'(a_if.tens), 32'(tens));
    check({tag, ".ones"}, 32'(a_if.ones), 32'(ones));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Clear has priority over a simultaneous load.
    cs = 1'b1;
    a_if.ld = 1'b1;  a_if.d = 8'd55; a_if.en = 1'b0; a_if.cai = 1'b0;
    lo_if.ld = 1'b0; lo_if.d = 8'd0; lo_if.en = 1'b0; lo_if.cai = 1'b0;
    hi_if.ld = 1'b0; hi_if.d = 8'd0; hi_if.en = 1'b0;
    m_if.ld = 1'b0;  m_if.d = 8'd0;  m_if.en = 1'b0;  m_if.cai = 1'b0;
    step();
    check_a("rst", 0, 0, 0, 0, 0);
    check("rst_lo.q", 32'(lo_if.q), 0);
    check("rst_m.q", 32'(m_if.q), 0);
    cs = 1'b0;

    // Load 97 then count through the wrap.
    a_if.ld = 1'b1; a_if.d = 8'd97;
    step();
    check_a("ld97", 97, 0, 0, 9, 7);
    a_if.ld = 1'b0; a_if.en = 1'b1; a_if.cai = 1'b1;
    #1;
    check("cao_at97", 32'(a_if.cao), 0);
    step();
    check_a("cnt98", 98, 0, 0, 9, 8);
    step();
    check_a("cnt99", 99, 1, 0, 9, 9);
    step();
    check_a("wrap0", 0, 0, 0, 0, 0);

    // Illegal load freezes counting.
    a_if.ld = 1'b1; a_if.d = 8'd150;
    step();
    a_if.ld = 1'b0;
    #1;
    check_a("ld150", 150, 0, 1, 0, 0);
    repeat (5) step();
    check_a("hold150", 150, 0, 1, 0, 0);
    a_if.ld = 1'b1; a_if.d = 8'd10;
    step();
    check_a("ld10", 10, 0, 0, 1, 0);

    // Carry-in gating.
    a_if.d = 8'd42; a_if.en = 1'b0;
    step();
    check_a("ld42", 42, 0, 0, 4, 2);
    a_if.ld = 1'b0; a_if.en = 1'b1; a_if.cai = 1'b1;
    step();
    check("cai1a.q", 32'(a_if.q), 43);
    a_if.cai = 1'b0;
    step();
    check("cai0a.q", 32'(a_if.q), 43);
    a_if.cai = 1'b1;
    step();
    check("cai1b.q", 32'(a_if.q), 44);
    a_if.cai = 1'b0;
    step();
    check("cai0b.q", 32'(a_if.q), 44);
    a_if.en = 1'b0; a_if.cai = 1'b1;
    step();
    check_a("en0", 44, 0, 0, 4, 4);

    // Clear wins mid-count, and cao at 99 is dropped by en=0.
    a_if.ld = 1'b1; a_if.d = 8'd99;
    step();
    a_if.ld = 1'b0;
    #1;
    check("en0_at99.cao", 32'(a_if.cao), 0);
    a_if.en = 1'b1;
    #1;
    check("en1_at99.cao", 32'(a_if.cao), 1);
    cs = 1'b1;
    step();
    cs = 1'b0;
    check_a("cs_mid", 0, 0, 0, 0, 0);
    a_if.en = 1'b0;

    // Cascade: low 99 -> 0 advances high 4 -> 5 on the same edge.
    lo_if.ld = 1'b1; lo_if.d = 8'd99;
    hi_if.ld = 1'b1; hi_if.d = 8'd4;
    step();
    lo_if.ld = 1'b0; hi_if.ld = 1'b0;
    lo_if.en = 1'b1; lo_if.cai = 1'b1; hi_if.en = 1'b1;
    #1;
    check("casc_lo.cao", 32'(lo_if.cao), 1);
    check("casc_hi.q0", 32'(hi_if.q), 4);
    step();
    check("casc_lo.q1", 32'(lo_if.q), 0);
    check("casc_hi.q1", 32'(hi_if.q), 5);
    check("casc_hi.ones1", 32'(hi_if.ones), 5);
    step();
    check("casc_lo.q2", 32'(lo_if.q), 1);
    check("casc_hi.q2", 32'(hi_if.q), 5);
    lo_if.en = 1'b0;

    // Full-range modulus: 255 wraps to 0, no digits.
    m_if.ld = 1'b1; m_if.d = 8'd255;
    step();
    m_if.ld = 1'b0; m_if.en = 1'b1; m_if.cai = 1'b1;
    #1;
    check("m256.q255", 32'(m_if.q), 255);
    check("m256.cao255", 32'(m_if.cao), 1);
    check("m256.ill255", 32'(m_if.ill), 0);
    check("m256.tens255", 32'(m_if.tens), 0);
    check("m256.ones255", 32'(m_if.ones), 0);
    step();
    check("m256.q0", 32'(m_if.q), 0);
    check("m256.cao0", 32'(m_if.cao), 0);
    step();
    check("m256.q1", 32'(m_if.q), 1);
    check("m256.ones1", 32'(m_if.ones), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
